// File: rtl/poly_stream_reader_pkg.sv
// Shared NewHope definitions for the polynomial delay-buffer and pipeline blocks.
// Contents:
//   NH_N       - coefficients per NewHope polynomial
//   NH_ADDR_W  - polynomial RAM address width, clog2(NH_N)
//   NH_DATA_W  - coefficient width
//   rd_state_e - state encoding of the polynomial stream reader FSM
package poly_stream_reader_pkg;

    localparam int NH_N      = 512;
    localparam int NH_ADDR_W = 9;
    localparam int NH_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/poly_stream_reader_fifo.sv
// skid_fifo2: two-entry output buffer for the polynomial stream reader.
// Entry 0 is always the head, so a pop shifts entry 1 down.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   push_i        - write push_data_i this cycle
//   push_data_i   - word to store
//   pop_i         - drop the head this cycle
//   full_o        - both entries occupied
//   empty_o       - no entry stored
//   head_o        - stored head word (meaningless while empty_o=1)
// A push and a pop while empty means the caller consumed the word as it arrived,
// so nothing is stored.
module skid_fifo2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] entry0_q, entry0_d;
    logic [W-1:0] entry1_q, entry1_d;
    logic [1:0]   count_q, count_d;

    // Next contents: current list, plus the pushed word, minus the head if popped.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        case (count_q)
            2'd0: begin
                if (push_i && !pop_i) begin
                    entry0_d = push_data_i;
                    count_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && pop_i) begin
                    entry0_d = push_data_i;
                end else if (push_i) begin
                    entry1_d = push_data_i;
                    count_d  = 2'd2;
                end else if (pop_i) begin
                    count_d  = 2'd0;
                end
            end
            2'd2: begin
                if (pop_i) begin
                    entry0_d = entry1_q;
                    if (push_i) begin
                        entry1_d = push_data_i;
                    end else begin
                        count_d  = 2'd1;
                    end
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    // Storage registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = entry0_q;

endmodule

// File: rtl/poly_stream_reader.sv
// poly_stream_reader: streams one full NewHope polynomial out of the delay-buffer
// RAM in address order, with credit-based flow control into a 2-entry buffer.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   start               - one-cycle request to stream a polynomial
//   busy                - transfer in progress, through the done cycle
//   done, shift_req     - one-cycle pulse after the final handshake
//   rd_en, rd_addr      - RAM read strobe and address
//   rd_data             - RAM data, valid one cycle after rd_en
//   out_valid/out_ready - downstream handshake
//   out_data, out_last  - coefficient and end-of-polynomial marker
module poly_stream_reader
    import poly_stream_reader_pkg::*;
#(
    parameter int N      = NH_N,
    parameter int ADDR_W = NH_ADDR_W,
    parameter int DATA_W = NH_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              shift_req,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    rd_state_e         state_q;
    logic [ADDR_W-1:0] fetchCnt_q;
    logic              inFlight_q;
    logic              inFlightLast_q;
    logic              done_q;

    logic              fifoFull;
    logic              fifoEmpty;
    logic [DATA_W:0]   fifoHead;
    logic [DATA_W:0]   pushWord;
    logic [DATA_W:0]   headWord;
    logic              push;
    logic              pop;
    logic [1:0]        storedCnt;
    logic              credit;
    logic              atLastAddr;

    // Returning read data carries its own last marker, captured at issue time.
    assign push     = inFlight_q;
    assign pushWord = {inFlightLast_q, rd_data};

    // An arriving word is presented straight away when nothing is stored ahead of it,
    // which gives out_valid in the same cycle as the push.
    assign headWord  = fifoEmpty ? pushWord : fifoHead;
    assign out_valid = !fifoEmpty || push;
    assign pop       = out_valid && out_ready;

    // Credit: stored words plus the read in flight, less this cycle's pop, must stay below 2.
    assign storedCnt = fifoFull ? 2'd2 : (fifoEmpty ? 2'd0 : 2'd1);
    assign credit    = ({1'b0, storedCnt} + {2'b00, push}) < (3'd2 + {2'b00, pop});

    assign atLastAddr = (fetchCnt_q == LAST_ADDR);
    assign rd_en      = (state_q == ST_FETCH) && credit;
    assign rd_addr    = rd_en ? fetchCnt_q : '0;

    assign out_data  = out_valid ? headWord[DATA_W-1:0] : '0;
    assign out_last  = out_valid && headWord[DATA_W];
    assign busy      = (state_q != ST_IDLE) || done_q;
    assign done      = done_q;
    assign shift_req = done_q;

    skid_fifo2 #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push && !(fifoEmpty && pop)),
        .push_data_i (pushWord),
        .pop_i       (pop && !fifoEmpty),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty),
        .head_o      (fifoHead)
    );

    // Control FSM: fetch counter, in-flight tracking and the registered done pulse.
    // A start coinciding with done is ignored so the restart lands after the pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            fetchCnt_q     <= '0;
            inFlight_q     <= 1'b0;
            inFlightLast_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            inFlight_q     <= rd_en;
            inFlightLast_q <= rd_en && atLastAddr;
            done_q         <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !done_q) begin
                        state_q    <= ST_FETCH;
                        fetchCnt_q <= '0;
                    end
                end
                ST_FETCH: begin
                    if (rd_en) begin
                        if (atLastAddr) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            fetchCnt_q <= fetchCnt_q + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && headWord[DATA_W]) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/poly_stream_reader.md
POLY_STREAM_READER -- requirements
Module: poly_stream_reader

Interface
REQ-001 Parameter N, default 512: coefficients per NewHope polynomial.
REQ-002 Parameter ADDR_W, default 9: polynomial RAM address width, equal to clog2(N).
REQ-003 Parameter DATA_W, default 16: coefficient width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 start  input  1  one-cycle request to stream one full polynomial.
REQ-007 busy  output  1  high from start acceptance until the done cycle, inclusive.
REQ-008 done  output  1  one-cycle pulse after the final coefficient handshake.
REQ-009 shift_req  output  1  one-cycle pulse coincident with done; advances the delay-buffer slot rotation.
REQ-010 rd_en  output  1  read strobe to the delay-buffer output port.
REQ-011 rd_addr  output  ADDR_W  read address; meaningful only when rd_en=1.
REQ-012 rd_data  input  DATA_W  synchronous RAM data, valid exactly one cycle after the rd_en cycle.
REQ-013 out_valid  output  1  coefficient available on out_data.
REQ-014 out_ready  input  1  downstream accepts; a handshake is out_valid and out_ready in the same cycle.
REQ-015 out_data  output  DATA_W  coefficient value.
REQ-016 out_last  output  1  high with the coefficient read from address N-1.

Function
REQ-017 The FSM SHALL have three states: IDLE, FETCH and DRAIN.
REQ-018 In IDLE, start=1 SHALL move the FSM to FETCH and clear the fetch counter to 0; in any other state, start SHALL be ignored.
REQ-019 In FETCH, rd_en SHALL assert and rd_addr SHALL equal the fetch counter whenever a credit is available; the fetch counter SHALL then increment.
REQ-020 The output buffer SHALL be a 2-entry FIFO; a credit is available when FIFO occupancy plus in-flight reads, minus a pop in the current cycle, is less than 2.
REQ-021 In FETCH, a read issued at address N-1 SHALL move the FSM to DRAIN; the fetch counter SHALL never wrap past N-1.
REQ-022 rd_data SHALL be pushed into the FIFO on the cycle after each rd_en, unconditionally; the credit rule guarantees no overflow.
REQ-023 out_valid SHALL be high iff the FIFO is non-empty; out_data and out_last SHALL come from the FIFO head.
REQ-024 out_valid, out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 In DRAIN, a handshake with out_last=1 SHALL pulse done and shift_req in the following cycle and return the FSM to IDLE.
REQ-026 Latency: start in cycle 0 gives rd_en in cycle 1, FIFO push in cycle 2 and out_valid in cycle 2.
REQ-027 Throughput: with out_ready held high, the block SHALL deliver one coefficient per cycle; the N-th handshake occurs in cycle N+1 and done in cycle N+2.
REQ-028 A start in the same cycle as done SHALL be ignored; the earliest accepted restart is the cycle after done.
REQ-029 Coefficients SHALL appear in strict address order 0..N-1, exactly once each, with no gaps or duplicates under any out_ready pattern.

Reset
REQ-030 With rst_n=0 at a clock edge, the block SHALL enter IDLE, clear the fetch counter, empty the FIFO and clear the in-flight flag.
REQ-031 While in reset, outputs SHALL be busy=0, done=0, shift_req=0, rd_en=0, rd_addr=0, out_valid=0, out_data=0 and out_last=0.
REQ-032 A reset mid-stream SHALL abort the transfer without pulsing done or shift_req; rd_data returning after reset SHALL be discarded.

Structure
REQ-033 N, ADDR_W, DATA_W and the FSM state encoding SHALL live in the shared NewHope package used by the delay-buffer and pipeline blocks.
REQ-034 The 2-entry FIFO SHALL be one sub-module, skid_fifo2, with push, pop, full, empty and head data ports; the FSM and credit logic stay in the top level.

Verification
REQ-035 With RAM[i]=i and out_ready=1, a start in cycle 0 SHALL give out_data 0..511 in cycles 2..513, out_last in cycle 513, and done and shift_req in cycle 514.
REQ-036 With out_ready=0 for cycles 0..20 after start, SHALL see exactly 2 reads issued, out_valid=1 with out_data=0 held stable, and no third rd_en.
REQ-037 With out_ready toggling 1,0,1,0 and RAM[i]=0xFFFF-i, the stream SHALL be the complete ordered sequence 0xFFFF..0xFE00, with out_last only on 0xFE00.
REQ-038 A second start pulsed in cycle 100 of a transfer SHALL be ignored: only 512 coefficients are delivered and there is one done pulse.
REQ-039 Asserting rst_n=0 in cycle 300 SHALL make all outputs 0 in the next cycle, with no done; a subsequent start SHALL stream again from address 0.
REQ-040 With N=8 and out_ready low for the single cycle carrying address 7, out_last SHALL be held until the handshake, then done follows one cycle later.
